// File: rtl/seg_scan_reader.sv
// rtl/seg_scan_reader.sv - multiplexed 7-segment bus sampler, debouncer and frame publisher
//
// Watches a multiplexed 7-segment display bus. Each digit slot is debounced
// (STABLE identical one-hot samples), decoded back to a BCD value, and held in
// a shadow register. Once every slot has been captured in the current scan,
// the whole shadow word is published atomically on the following edge.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg_in[6:0]  segment lines a..g (bit6=a .. bit0=g), active-high
//   dig_in       one-hot digit enables, bit i selects slot i
//   values       published digit values, slot i at [4i+3:4i]
//   invalid      per-slot flag: published pattern was not a legal 0-9 glyph
//   frame_valid  one-cycle pulse when values/invalid update
//   err_multi    one-cycle pulse, registered, for each multi-hot dig_in sample

module seg_scan_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_in,
    output logic [4*DIGITS-1:0]   values,
    output logic [DIGITS-1:0]     invalid,
    output logic                  frame_valid,
    output logic                  err_multi
);

    localparam int              CW       = $clog2(STABLE) + 1;
    localparam logic [CW-1:0]   STABLE_C = CW'(STABLE);
    localparam logic [DIGITS-1:0] ONE_D  = DIGITS'(1);

    // Previous bus sample, stability counter and frame collection state
    logic [6:0]          prev_seg_q, prev_seg_d;
    logic [DIGITS-1:0]   prev_dig_q, prev_dig_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_inv_q, shadow_inv_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                pub_q, pub_d;

    // Published outputs
    logic [4*DIGITS-1:0] values_q, values_d;
    logic [DIGITS-1:0]   invalid_q, invalid_d;
    logic                frame_valid_q, frame_valid_d;
    logic                err_multi_q, err_multi_d;

    // Combinational helpers
    logic       same;
    logic       onehot;
    logic       multi;
    logic       capture;
    logic [3:0] dec_val;
    logic       dec_inv;

    // Glyph decode: anything outside the ten legal patterns is flagged.
    always_comb begin
        dec_val = 4'hF;
        dec_inv = 1'b0;
        case (seg_in)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_inv = 1'b1;
            end
        endcase
    end

    always_comb begin
        same   = (seg_in == prev_seg_q) && (dig_in == prev_dig_q);
        onehot = (dig_in != '0) && ((dig_in & (dig_in - ONE_D)) == '0);
        multi  = (dig_in != '0) && !onehot;

        // Saturating run-length counter; a new one-hot combination starts at 1
        // so that the STABLE-th identical sample lands on cnt == STABLE.
        if (!onehot) begin
            cnt_d = '0;
        end else if (!same) begin
            cnt_d = CW'(1);
        end else if (cnt_q == STABLE_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Capture only on the edge the run first reaches STABLE; a saturated
        // run (same sample, counter already at STABLE) never re-captures.
        capture = onehot && (cnt_d == STABLE_C) && !(same && (cnt_q == STABLE_C));
    end

    always_comb begin
        prev_seg_d    = seg_in;
        prev_dig_d    = dig_in;
        shadow_val_d  = shadow_val_q;
        shadow_inv_d  = shadow_inv_q;
        values_d      = values_q;
        invalid_d     = invalid_q;
        frame_valid_d = pub_q;
        err_multi_d   = multi;

        // Publication reads the shadow before this edge's capture updates it,
        // so a first-digit capture of the next frame cannot leak into the word.
        if (pub_q) begin
            values_d  = shadow_val_q;
            invalid_d = shadow_inv_q;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (capture && dig_in[i]) begin
                shadow_val_d[4*i +: 4] = dec_val;
                shadow_inv_d[i]        = dec_inv;
            end
        end

        // Clearing on publication and setting from a same-edge capture are
        // combined so the next frame's first digit is kept.
        mask_d = (pub_q ? '0 : mask_q) | (capture ? dig_in : '0);
        pub_d  = capture && (&mask_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_seg_q    <= '0;
            prev_dig_q    <= '0;
            cnt_q         <= '0;
            shadow_val_q  <= '0;
            shadow_inv_q  <= '0;
            mask_q        <= '0;
            pub_q         <= 1'b0;
            values_q      <= '0;
            invalid_q     <= '0;
            frame_valid_q <= 1'b0;
            err_multi_q   <= 1'b0;
        end else begin
            prev_seg_q    <= prev_seg_d;
            prev_dig_q    <= prev_dig_d;
            cnt_q         <= cnt_d;
            shadow_val_q  <= shadow_val_d;
            shadow_inv_q  <= shadow_inv_d;
            mask_q        <= mask_d;
            pub_q         <= pub_d;
            values_q      <= values_d;
            invalid_q     <= invalid_d;
            frame_valid_q <= frame_valid_d;
            err_multi_q   <= err_multi_d;
        end
    end

    assign values      = values_q;
    assign invalid     = invalid_q;
    assign frame_valid = frame_valid_q;
    assign err_multi   = err_multi_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb/tb_seg_scan_reader.sv - directed self-checking bench for seg_scan_reader

module tb_seg_scan_reader;

    localparam logic [6:0] G0  = 7'b1111110;
    localparam logic [6:0] G1  = 7'b0110000;
    localparam logic [6:0] G2  = 7'b1101101;
    localparam logic [6:0] G3  = 7'b1111001;
    localparam logic [6:0] G4  = 7'b0110011;
    localparam logic [6:0] G5  = 7'b1011011;
    localparam logic [6:0] G6  = 7'b1011111;
    localparam logic [6:0] G7  = 7'b1110000;
    localparam logic [6:0] G8  = 7'b1111111;
    localparam logic [6:0] G9  = 7'b1111011;
    localparam logic [6:0] BAD = 7'b1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_in;
    logic [15:0] values;
    logic [3:0]  invalid;
    logic        frame_valid;
    logic        err_multi;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    int err_count = 0;

    seg_scan_reader #(.DIGITS(4), .STABLE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_in      (dig_in),
        .values      (values),
        .invalid     (invalid),
        .frame_valid (frame_valid),
        .err_multi   (err_multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) fv_count++;
        if (err_multi === 1'b1) err_count++;
    end

    task automatic show(input int d, input logic [6:0] p, input int n);
        dig_in = 4'b0001 << d;
        seg_in = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        dig_in = 4'b0000;
        seg_in = 7'b0000000;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dig_in = 4'b0000;
        seg_in = 7'b0000000;
        repeat (3) @(negedge clk);
        checks++;
        if (values !== 16'h0000) begin errors++; $display("FAIL reset_values: got %h expected %h", values, 16'h0000); end
        checks++;
        if (invalid !== 4'h0) begin errors++; $display("FAIL reset_invalid: got %b expected %b", invalid, 4'h0); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
        checks++;
        if (err_multi !== 1'b0) begin errors++; $display("FAIL reset_err_multi: got %b expected 0", err_multi); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_scan;
        int base;
        base = fv_count;
        show(0, G3, 8); blank(2);
        show(1, G4, 8); blank(2);
        show(2, G5, 8); blank(2);
        dig_in = 4'b1000;
        seg_in = G0;
        repeat (4) @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL clean_fv_early: got %b expected 0", frame_valid); end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL clean_fv_edge: got %b expected 1", frame_valid); end
        checks++;
        if (values !== 16'h0543) begin errors++; $display("FAIL clean_values: got %h expected %h", values, 16'h0543); end
        checks++;
        if (invalid !== 4'b0000) begin errors++; $display("FAIL clean_invalid: got %b expected %b", invalid, 4'b0000); end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL clean_fv_pulse: got %b expected 0", frame_valid); end
        repeat (2) @(negedge clk);
        blank(2);
        checks++;
        if (fv_count - base !== 1) begin errors++; $display("FAIL clean_fv_count: got %0d expected 1", fv_count - base); end
    endtask

    task automatic test_glitch;
        int base;
        base = fv_count;
        show(0, G3, 8); blank(2);
        show(1, G7, 3); blank(2);
        show(2, G5, 8); blank(2);
        show(3, G0, 8); blank(2);
        checks++;
        if (fv_count - base !== 0) begin errors++; $display("FAIL glitch_no_frame: got %0d expected 0", fv_count - base); end
        show(1, G1, 8); blank(2);
        checks++;
        if (fv_count - base !== 1) begin errors++; $display("FAIL glitch_fv_count: got %0d expected 1", fv_count - base); end
        checks++;
        if (values !== 16'h0513) begin errors++; $display("FAIL glitch_values: got %h expected %h", values, 16'h0513); end
    endtask

    task automatic test_illegal;
        int base;
        base = fv_count;
        show(0, G3, 8); blank(2);
        show(1, G4, 8); blank(2);
        show(2, BAD, 8); blank(2);
        show(3, G0, 8); blank(2);
        checks++;
        if (fv_count - base !== 1) begin errors++; $display("FAIL illegal_fv_count: got %0d expected 1", fv_count - base); end
        checks++;
        if (values !== 16'h0F43) begin errors++; $display("FAIL illegal_values: got %h expected %h", values, 16'h0F43); end
        checks++;
        if (invalid !== 4'b0100) begin errors++; $display("FAIL illegal_invalid: got %b expected %b", invalid, 4'b0100); end
    endtask

    task automatic test_multi_hot;
        int base_fv;
        int base_err;
        base_fv = fv_count;
        base_err = err_count;
        show(0, G1, 8); blank(2);
        show(1, G2, 8); blank(2);
        show(2, G3, 8); blank(2);
        dig_in = 4'b0011;
        seg_in = G8;
        @(negedge clk);
        checks++;
        if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_err_first: got %b expected 1", err_multi); end
        repeat (5) @(negedge clk);
        checks++;
        if (err_multi !== 1'b1) begin errors++; $display("FAIL multi_err_last: got %b expected 1", err_multi); end
        dig_in = 4'b0000;
        seg_in = 7'b0000000;
        @(negedge clk);
        checks++;
        if (err_multi !== 1'b0) begin errors++; $display("FAIL multi_err_clear: got %b expected 0", err_multi); end
        blank(2);
        checks++;
        if (err_count - base_err !== 6) begin errors++; $display("FAIL multi_err_count: got %0d expected 6", err_count - base_err); end
        checks++;
        if (fv_count - base_fv !== 0) begin errors++; $display("FAIL multi_no_frame: got %0d expected 0", fv_count - base_fv); end
        show(3, G4, 8); blank(2);
        checks++;
        if (fv_count - base_fv !== 1) begin errors++; $display("FAIL multi_fv_count: got %0d expected 1", fv_count - base_fv); end
        checks++;
        if (values !== 16'h4321) begin errors++; $display("FAIL multi_values: got %h expected %h", values, 16'h4321); end
    endtask

    task automatic test_back_to_back;
        int base;
        base = fv_count;
        show(0, G2, 8); blank(2);
        show(0, G7, 8); blank(2);
        show(1, G8, 8); blank(2);
        show(2, G9, 8); blank(2);
        dig_in = 4'b1000;
        seg_in = G6;
        repeat (4) @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL b2b_fv_early: got %b expected 0", frame_valid); end
        // next scan's first digit is first sampled on the publication edge
        dig_in = 4'b0001;
        seg_in = G9;
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_fv_edge: got %b expected 1", frame_valid); end
        checks++;
        if (values !== 16'h6987) begin errors++; $display("FAIL b2b_overwrite_values: got %h expected %h", values, 16'h6987); end
        repeat (7) @(negedge clk);
        blank(2);
        show(1, G0, 8); blank(2);
        checks++;
        if (values !== 16'h6987) begin errors++; $display("FAIL b2b_hold_values: got %h expected %h", values, 16'h6987); end
        show(2, G5, 8); blank(2);
        show(3, G2, 8); blank(2);
        checks++;
        if (fv_count - base !== 2) begin errors++; $display("FAIL b2b_fv_count: got %0d expected 2", fv_count - base); end
        checks++;
        if (values !== 16'h2509) begin errors++; $display("FAIL b2b_second_values: got %h expected %h", values, 16'h2509); end
        checks++;
        if (invalid !== 4'b0000) begin errors++; $display("FAIL b2b_invalid: got %b expected %b", invalid, 4'b0000); end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        show(0, G5, 8); blank(2);
        show(1, G6, 8); blank(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (values !== 16'h0000) begin errors++; $display("FAIL rstmid_values: got %h expected %h", values, 16'h0000); end
        checks++;
        if (invalid !== 4'b0000) begin errors++; $display("FAIL rstmid_invalid: got %b expected %b", invalid, 4'b0000); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fv: got %b expected 0", frame_valid); end
        base = fv_count;
        show(2, G7, 8); blank(2);
        show(3, G8, 8); blank(2);
        checks++;
        if (fv_count - base !== 0) begin errors++; $display("FAIL rstmid_partial_frame: got %0d expected 0", fv_count - base); end
        show(0, G0, 8); blank(2);
        show(1, G9, 8); blank(2);
        checks++;
        if (fv_count - base !== 1) begin errors++; $display("FAIL rstmid_fv_count: got %0d expected 1", fv_count - base); end
        checks++;
        if (values !== 16'h8790) begin errors++; $display("FAIL rstmid_values_after: got %h expected %h", values, 16'h8790); end
    endtask

    initial begin
        rst = 1'b1;
        dig_in = 4'b0000;
        seg_in = 7'b0000000;
        @(negedge clk);
        test_reset;
        test_clean_scan;
        test_glitch;
        test_illegal;
        test_multi_hot;
        test_back_to_back;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
